// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide path. The ALU-control
// decoder and muldiv_unit both use these, so the funct3 encodings and the
// FSM state encoding live in one place.
//   OP_*        : 3-bit RV32M funct3 encodings
//   state_t     : muldiv_unit FSM states
//   op_is_div   : op belongs to the divide/remainder group
//   op_is_rem   : op returns a remainder
//   op_a_signed : rs1 is read as a two's-complement value
//   op_b_signed : rs2 is read as a two's-complement value
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [2:0] o);
    return o[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] o);
    return o[2] & o[1];
  endfunction

  // MUL reads both operands as signed; the low half of the product is the
  // same either way.
  function automatic logic op_a_signed(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
           (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit. It does one shift-add (multiply) or
// one restoring-subtract (divide) step per cycle on operand magnitudes,
// using a single WIDTH+1 adder/subtractor. The sign is fixed up when the
// result is registered.
//   clk, rst             : clock and asynchronous active-high reset
//   in_valid, in_ready   : request handshake; op/a/b captured on accept
//   op, a, b             : funct3 and operands rs1/rs2
//   out_valid, out_ready : result handshake
//   result, zero         : operation result and result==0 flag
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;      // product high half / partial remainder
  logic [WIDTH-1:0] mq;       // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd;     // multiplicand / divisor magnitude
  logic [2:0]       op_r;
  logic             neg_lo;   // negate product or quotient
  logic             neg_hi;   // negate remainder
  logic [WIDTH-1:0] result_r;
  logic             zero_r;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             special;
  logic [WIDTH-1:0] special_res;

  logic             is_mul;
  logic [WIDTH:0]   add_x, add_y;
  logic [WIDTH+1:0] add_full;
  logic [WIDTH:0]   add_s;
  logic             add_cout;
  logic [WIDTH:0]   mul_hi;
  logic [WIDTH-1:0] acc_step, mq_step;
  logic [2*WIDTH-1:0] product, product_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix, final_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign zero      = zero_r;
  assign accept    = in_valid && in_ready;

  // Operand decode at accept time: magnitudes plus the division corner cases
  // that can be answered without iterating.
  always_comb begin
    a_neg       = op_a_signed(op) && a[WIDTH-1];
    b_neg       = op_b_signed(op) && b[WIDTH-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    special     = 1'b0;
    special_res = '0;
    if (op_is_div(op) && (b == '0)) begin
      special     = 1'b1;
      special_res = op_is_rem(op) ? a : '1;
    end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1)) begin
      special     = 1'b1;
      special_res = op_is_rem(op) ? '0 : a;
    end
  end

  // Shared adder: multiply adds the multiplicand into the high half, divide
  // subtracts the divisor from the shifted partial remainder. For divide the
  // carry-out is the "no borrow" flag, i.e. the next quotient bit.
  always_comb begin
    is_mul   = ~op_r[2];
    add_x    = is_mul ? {1'b0, acc} : {acc, mq[WIDTH-1]};
    add_y    = is_mul ? {1'b0, opnd} : ~{1'b0, opnd};
    add_full = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, ~is_mul};
    add_s    = add_full[WIDTH:0];
    add_cout = add_full[WIDTH+1];
    mul_hi   = mq[0] ? add_s : {1'b0, acc};
    if (is_mul) begin
      acc_step = mul_hi[WIDTH:1];
      mq_step  = {mul_hi[0], mq[WIDTH-1:1]};
    end else begin
      acc_step = add_cout ? add_s[WIDTH-1:0] : add_x[WIDTH-1:0];
      mq_step  = {mq[WIDTH-2:0], add_cout};
    end
  end

  // Sign fix-up of the value produced by the final iteration.
  always_comb begin
    product     = {acc_step, mq_step};
    product_fix = neg_lo ? -product : product;
    quot_fix    = neg_lo ? -mq_step : mq_step;
    rem_fix     = neg_hi ? -acc_step : acc_step;
    case (op_r)
      OP_MUL:                     final_res = product_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = product_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:            final_res = quot_fix;
      default:                    final_res = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; corner-case divides skip BUSY when FAST_SPECIAL is set.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (FAST_SPECIAL && special) ? DONE : BUSY;
      BUSY: if (count == CW'(1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers. Accept loads magnitudes and sign flags; each BUSY
  // cycle is one iteration, and the last one also registers the result.
  // A zero divisor never negates the quotient, so the all-ones answer also
  // comes out of the iterative path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      op_r     <= OP_MUL;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r   <= op;
          acc    <= '0;
          count  <= CW'(WIDTH);
          mq     <= op_is_div(op) ? a_mag : b_mag;
          opnd   <= op_is_div(op) ? b_mag : a_mag;
          neg_lo <= op_is_div(op) ? ((a_neg ^ b_neg) && (b != '0)) : (a_neg ^ b_neg);
          neg_hi <= op_is_div(op) && a_neg;
          if (FAST_SPECIAL && special) begin
            result_r <= special_res;
            zero_r   <= (special_res == '0);
          end
        end
        BUSY: begin
          acc   <= acc_step;
          mq    <= mq_step;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result_r <= final_res;
            zero_r   <= (final_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32, FAST_SPECIAL=1). Results
// are compared with a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          zero;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(W), .FAST_SPECIAL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  // RV32M reference computed with 64-bit integer arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    int qi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        qi = $signed(x) / $signed(y);
        return qi;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        qi = $signed(x) % $signed(y);
        return qi;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    return (o[2] && y == 0) ||
           ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction. Call #1 after a rising edge with the unit idle.
  // hold: cycles out_ready stays low in DONE; pulse: inject an in_valid
  // during BUSY that must be ignored.
  task automatic apply_stimulus(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input string tag, input int hold, input bit pulse);
    logic [W-1:0] exp;
    int n;
    int lat_exp;
    exp = model(o, x, y);
    lat_exp = is_fast(o, x, y) ? 0 : W;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (!out_valid && n < 200) begin
      if (pulse && n == 5) in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end
    // edges after the accept edge before out_valid is seen
    check_output({tag, " latency"}, 64'(n), 64'(lat_exp));
    check_output({tag, " result"}, 64'(result), 64'(exp));
    check_output({tag, " zero"}, 64'(zero), 64'(exp == 0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output({tag, " hold"}, {30'b0, out_valid, in_ready, result}, {30'b0, 1'b1, 1'b0, exp});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output({tag, " release"}, {62'b0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int n;

    #12;
    check_output("reset state", {31'b0, out_valid, in_ready, zero, result},
                 {31'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    apply_stimulus(3'd0, 32'h0000000F, 32'h00000003, "mul 15x3", 0, 0);
    apply_stimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh -1x-1", 0, 0);
    apply_stimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu", 0, 0);
    apply_stimulus(3'd2, 32'hFFFFFFFF, 32'h00000002, "mulhsu", 0, 0);
    apply_stimulus(3'd4, 32'hFFFFFFF9, 32'h00000002, "div -7/2", 0, 0);
    apply_stimulus(3'd6, 32'hFFFFFFF9, 32'h00000002, "rem -7/2", 0, 0);
    apply_stimulus(3'd5, 32'h0000000F, 32'h00000003, "divu 15/3", 0, 0);
    apply_stimulus(3'd4, 32'h00000005, 32'h00000000, "div by 0", 0, 0);
    apply_stimulus(3'd7, 32'h00000005, 32'h00000000, "remu by 0", 0, 0);
    apply_stimulus(3'd6, 32'hFFFFFFF9, 32'h00000000, "rem neg by 0", 0, 0);
    apply_stimulus(3'd4, 32'hFFFFFFF9, 32'h00000000, "div neg by 0", 0, 0);
    apply_stimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, "div overflow", 0, 0);
    apply_stimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem overflow", 0, 0);
    apply_stimulus(3'd0, 32'h12345678, 32'h9ABCDEF0, "mul backpressure", 5, 1);

    // Reset at iteration 10 abandons the operation.
    in_valid = 1'b1; op = 3'd0; a = 32'h00000007; b = 32'h00000009;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    check_output("mid-busy reset", {31'b0, out_valid, in_ready, zero, result},
                 {31'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (n < 3) begin @(posedge clk); #1; n++; end
    check_output("no result after reset", 64'(out_valid), 64'b0);
    apply_stimulus(3'd5, 32'h00000064, 32'h00000007, "divu after reset", 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 0;
        default: ;
      endcase
      apply_stimulus(ro, ra, rb, "random", 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
